// File: rtl/power_sum_iter_if.sv
// Request/response bundle for power_sum_iter.
// The producer/consumer side uses the master modport and the datapath uses the slave modport.
interface power_sum_iter_if #(
    parameter int WIDTH     = 32,
    parameter int MAX_POWER = 3
);
    localparam int EW = $clog2(MAX_POWER + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [EW-1:0]    in_exp;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_exp, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_exp, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/power_sum_iter.sv
// power_sum_iter: computes (a^e + b^e) mod 2^WIDTH with a runtime exponent.
// Each exponent step costs one multiply cycle. A sticky flag reports whether the
// true result did not fit in WIDTH bits. A new request is taken only when the
// previous result has been handed off, so requests never overlap.
module power_sum_iter #(
    parameter int WIDTH     = 32,
    parameter int MAX_POWER = 3
) (
    input logic              clk,
    input logic              rst_n,
    power_sum_iter_if.slave  bus
);
    localparam int EW = $clog2(MAX_POWER + 1);
    localparam logic [EW-1:0] MAX_E = EW'(MAX_POWER);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   acc_a;
    logic [WIDTH-1:0]   acc_b;
    logic [EW-1:0]      cnt;
    logic               ovf;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_ovf_q;

    logic [EW-1:0]      exp_sat;
    logic               accept;
    logic [2*WIDTH-1:0] prod_a;
    logic [2*WIDTH-1:0] prod_b;
    logic               mul_ovf;
    logic [WIDTH:0]     sum;

    // Clamp the requested exponent to the largest supported power.
    always_comb begin
        exp_sat = bus.in_exp;
        if (int'(bus.in_exp) > MAX_POWER) begin
            exp_sat = MAX_E;
        end
    end

    // Full-width products and carry-extended sum used by the datapath.
    always_comb begin
        prod_a  = {{WIDTH{1'b0}}, acc_a} * {{WIDTH{1'b0}}, op_a};
        prod_b  = {{WIDTH{1'b0}}, acc_b} * {{WIDTH{1'b0}}, op_b};
        mul_ovf = (|prod_a[2*WIDTH-1:WIDTH]) | (|prod_b[2*WIDTH-1:WIDTH]);
        sum     = {1'b0, acc_a} + {1'b0, acc_b};
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = (exp_sat != '0) ? MUL : ADD;
                end
            end
            MUL: begin
                if (cnt == EW'(1)) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, iterative multiply and final add with overflow tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            acc_a      <= '0;
            acc_b      <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_a  <= bus.in_a;
                op_b  <= bus.in_b;
                acc_a <= WIDTH'(1);
                acc_b <= WIDTH'(1);
                cnt   <= exp_sat;
                ovf   <= 1'b0;
            end else if (state == MUL) begin
                acc_a <= prod_a[WIDTH-1:0];
                acc_b <= prod_b[WIDTH-1:0];
                ovf   <= ovf | mul_ovf;
                cnt   <= cnt - EW'(1);
            end else if (state == ADD) begin
                out_data_q <= sum[WIDTH-1:0];
                out_ovf_q  <= ovf | sum[WIDTH];
            end
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.out_ovf  = out_ovf_q;
endmodule

// File: tb/tb_power_sum_iter.sv
// Testbench for power_sum_iter: directed cases plus randomized requests checked
// against a wide-arithmetic reference model of a^e + b^e.
module tb_power_sum_iter;
    localparam int WIDTH     = 32;
    localparam int MAX_POWER = 3;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    power_sum_iter_if #(.WIDTH(WIDTH), .MAX_POWER(MAX_POWER)) bus ();

    power_sum_iter #(.WIDTH(WIDTH), .MAX_POWER(MAX_POWER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [127:0] truePow(input logic [31:0] base, input int e);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 0; i < e; i++) begin
            r = r * {96'd0, base};
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one request, check latency, result, stall behaviour and handoff.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int e, input int stall);
        logic [127:0] trueSum;
        logic [31:0]  expData;
        logic         expOvf;
        int           waitCnt;
        int           lat;
        int           emin;

        emin    = (e > MAX_POWER) ? MAX_POWER : e;
        trueSum = truePow(a, emin) + truePow(b, emin);
        expData = trueSum[31:0];
        expOvf  = (trueSum[127:32] != '0);

        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_exp    = 2'(e);
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);

        waitCnt = 0;
        while (!bus.in_ready && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("in_ready_before_accept", 64'(bus.in_ready), 64'd1);

        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("in_ready_busy", 64'(bus.in_ready), 64'd0);

        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(emin + 1));
        checkOutput("out_data", 64'(bus.out_data), 64'(expData));
        checkOutput("out_ovf", 64'(bus.out_ovf), 64'(expOvf));

        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
            @(posedge clk); #1;
            checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("stall_data", 64'(bus.out_data), 64'(expData));
            checkOutput("stall_ovf", 64'(bus.out_ovf), 64'(expOvf));
            checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("handoff_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("handoff_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("held_data", 64'(bus.out_data), 64'(expData));
    endtask

    // Main sequence: reset, directed cases, mid-operation reset, random requests.
    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(bus.out_data), 64'd0);
        checkOutput("reset_out_ovf", 64'(bus.out_ovf), 64'd0);
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);

        applyStimulus(32'd2, 32'd3, 3, 0);
        checkOutput("cube_sum_35", 64'(bus.out_data), 64'd35);
        applyStimulus(32'd7, 32'd0, 0, 0);
        applyStimulus(32'h0001_0000, 32'd0, 2, 0);
        checkOutput("mul_ovf_flag", 64'(bus.out_ovf), 64'd1);
        applyStimulus(32'd3, 32'd4, 2, 0);
        checkOutput("ovf_cleared", 64'(bus.out_ovf), 64'd0);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1, 0);
        checkOutput("add_carry_ovf", 64'(bus.out_ovf), 64'd1);
        applyStimulus(32'd1, 32'd1, 3, 5);
        applyStimulus(32'd0, 32'd1, 3, 0);

        bus.in_a      = 32'd5;
        bus.in_b      = 32'd5;
        bus.in_exp    = 2'd3;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midreset_out_data", 64'(bus.out_data), 64'd0);
        checkOutput("midreset_out_ovf", 64'(bus.out_ovf), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'd1, 32'd2, 3, 0);
        checkOutput("after_reset_9", 64'(bus.out_data), 64'd9);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            if (n % 2 == 0) begin
                ra = $urandom_range(0, 1500);
                rb = $urandom_range(0, 1500);
            end else begin
                ra = $urandom;
                rb = $urandom;
            end
            applyStimulus(ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/power_sum_iter.md
Name: power_sum_iter

Overview:
- Parametrised successor to the fixed cube-sum datapath. Computes a^e + b^e with a runtime exponent e (0..MAX_POWER) using one iterative multiply step per cycle.
- Adds a valid/ready handshake on input and output, plus a sticky overflow flag.
- Sits in arithmetic test kernels where a fixed-latency cube adder was previously used; downstream logic consumes results via handshake instead of a fixed delay line.

Parameters:
- WIDTH, 32, operand and result width in bits (>=2).
- MAX_POWER, 3, largest supported exponent (>=1).
- EW, $clog2(MAX_POWER+1), width of exponent port (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  WIDTH  operand a, unsigned.
- in_b  input  WIDTH  operand b, unsigned.
- in_exp  input  EW  exponent e, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  (a^e + b^e) mod 2^WIDTH.
- out_ovf  output  1  the true result did not fit in WIDTH bits.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0; out_data=0; out_ovf=0; internal accumulators, counter and latched operands cleared. in_ready=1 once rst_n is high.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and e, where e=min(in_exp, MAX_POWER). Set acc_a=1, acc_b=1, cnt=e, ovf=0. Go to MUL if e>0, otherwise go to ADD.
  - MUL: in_ready=0. Each cycle: acc_a<=low WIDTH bits of acc_a*a; acc_b<=low WIDTH bits of acc_b*b; ovf|=(upper WIDTH bits of either 2*WIDTH-bit product !=0); cnt<=cnt-1. When cnt==1, go to ADD.
  - ADD: out_data<=(acc_a+acc_b) mod 2^WIDTH; out_ovf<=ovf|carry-out of that add. Go to DONE.
  - DONE: out_valid=1. out_data and out_ovf are held stable while out_ready=0. On out_ready=1, clear out_valid and go to IDLE. out_data and out_ovf retain their last values after the handshake.
- Latency: if the request is accepted at edge 0, out_valid is high after edge e+1 (e=0 gives 1 cycle, e=3 gives 4 cycles).
- Throughput: in_ready is high only in IDLE, so the minimum issue interval is e+3 cycles with out_ready tied high. There is no overlap between requests.
- in_valid while busy: ignored and not latched. The producer must hold its request until in_ready is seen.
- Overflow is sticky per operation: once a multiply step overflows, later steps continue on the wrapped value and the flag remains set. The flag is cleared at the next accept.
- Edge cases:
  - e=0 yields out_data=2, out_ovf=0, for any a and b (0^0 is treated as 1).
  - e > MAX_POWER (possible when MAX_POWER+1 is not a power of 2) saturates to MAX_POWER.
  - Operands of 0 or 1 never set ovf in MUL.
- Reset asserted mid-operation aborts immediately. No partial result is presented, and the first request after reset computes from clean state.
- Arithmetic is unsigned throughout. No combinational path from in_* to out_*.

Test Plan:
- WIDTH=32, MAX_POWER=3: a=2, b=3, e=3, out_ready=1 -> out_valid rises 4 cycles after accept; out_data=35, out_ovf=0; in_ready high one cycle later.
- e=0, a=7, b=0 -> out_data=2, out_ovf=0, out_valid 1 cycle after accept.
- Multiply overflow: a=0x00010000, b=0, e=2 -> out_data=0, out_ovf=1. Next request a=3, b=4, e=2 -> out_data=25, out_ovf=0 (flag cleared).
- Add carry: a=0xFFFFFFFF, b=1, e=1 -> out_data=0, out_ovf=1.
- Backpressure: a=1, b=1, e=3 with out_ready=0 for 5 cycles -> out_valid stays high and out_data=2 is stable throughout; in_valid pulsed during the stall is ignored (in_ready=0); the first out_ready=1 completes the handshake, then in_ready=1.
- Reset mid-operation: accept a=5, b=5, e=3, then pull rst_n low during MUL -> out_valid=0, out_data=0, out_ovf=0 immediately. After release, a=1, b=2, e=3 -> out_data=9.
